// File: rtl/systolic_mm_acc.sv
// Output-stationary systolic matrix multiplier with accumulate-across-jobs,
// signed/unsigned operands and saturating/wrapping result truncation.
module systolic_mm_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 4,
    parameter int N          = 4,
    parameter int P          = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic                          acc_mode,
    input  logic                          sat_mode,
    input  logic [M*N*DATA_WIDTH-1:0]     matrix_a,
    input  logic [N*P*DATA_WIDTH-1:0]     matrix_b,
    output logic                          busy,
    output logic                          done,
    output logic [M*P*OUT_WIDTH-1:0]      result_c,
    output logic                          sat_flag
);

    localparam int CNT_LAST = M+N+P-3;
    localparam int CW       = $clog2(M+N+P);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] UMAX = {OUT_WIDTH{1'b1}};

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   accept_s;
    logic                   sm_q, satm_q;
    logic                   busy_q, done_q, sat_q;
    logic [M*P*OUT_WIDTH-1:0] result_q;

    logic [DATA_WIDTH-1:0]  a_lat_q  [M][N];
    logic [DATA_WIDTH-1:0]  b_lat_q  [N][P];
    logic [DATA_WIDTH-1:0]  a_pipe_q [M][P];
    logic [DATA_WIDTH-1:0]  b_pipe_q [M][P];
    logic [ACC_WIDTH-1:0]   acc_q    [M][P];

    logic [DATA_WIDTH-1:0]  feed_a_s [M];
    logic [DATA_WIDTH-1:0]  feed_b_s [P];
    logic [DATA_WIDTH-1:0]  a_eff_s  [M][P];
    logic [DATA_WIDTH-1:0]  b_eff_s  [M][P];
    logic [ACC_WIDTH-1:0]   prod_s   [M][P];
    logic [M*P*OUT_WIDTH-1:0] res_s;
    logic                   sat_any_s;
    logic [OUT_WIDTH:0]     tr_s;

    function automatic logic [ACC_WIDTH-1:0] mac_term(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  sgn
    );
        logic signed [2*DATA_WIDTH-1:0] ps;
        logic [2*DATA_WIDTH-1:0]        pu;
        logic [ACC_WIDTH-1:0]           r;
        ps = $signed(a) * $signed(b);
        pu = a * b;
        if (sgn) begin
            r = ACC_WIDTH'(ps);
        end else begin
            r = ACC_WIDTH'(pu);
        end
        return r;
    endfunction

    // Returns {clamped, value}; the top bit marks a saturation event.
    function automatic logic [OUT_WIDTH:0] out_trunc(
        input logic [ACC_WIDTH-1:0] acc,
        input logic                 sgn,
        input logic                 sat
    );
        logic [ACC_WIDTH-1:0] hi;
        logic [OUT_WIDTH:0]   r;
        r = {1'b0, acc[OUT_WIDTH-1:0]};
        if (!sat) begin
            hi = {ACC_WIDTH{1'b0}};
        end else if (sgn) begin
            hi = ACC_WIDTH'($signed(acc) >>> (OUT_WIDTH-1));
            if ((hi != {ACC_WIDTH{1'b0}}) && (hi != {ACC_WIDTH{1'b1}})) begin
                r = acc[ACC_WIDTH-1] ? {1'b1, SMIN} : {1'b1, SMAX};
            end else begin
                r = {1'b0, acc[OUT_WIDTH-1:0]};
            end
        end else begin
            hi = acc >> OUT_WIDTH;
            if (hi != {ACC_WIDTH{1'b0}}) begin
                r = {1'b1, UMAX};
            end else begin
                r = {1'b0, acc[OUT_WIDTH-1:0]};
            end
        end
        return r;
    endfunction

    assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_OUT));

    // Next-state and step counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(CNT_LAST)) begin
                    state_d = S_OUT;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_OUT: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Edge feeders: row i sees A[i][cnt-i], column j sees B[cnt-j][j], zero elsewhere.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            feed_a_s[i] = {DATA_WIDTH{1'b0}};
            for (int k = 0; k < N; k++) begin
                if (int'(cnt_q) == i + k) begin
                    feed_a_s[i] = a_lat_q[i][k];
                end else begin
                    feed_a_s[i] = feed_a_s[i];
                end
            end
        end
        for (int j = 0; j < P; j++) begin
            feed_b_s[j] = {DATA_WIDTH{1'b0}};
            for (int k = 0; k < N; k++) begin
                if (int'(cnt_q) == j + k) begin
                    feed_b_s[j] = b_lat_q[k][j];
                end else begin
                    feed_b_s[j] = feed_b_s[j];
                end
            end
        end
    end

    // PE operand selection (a flows east, b flows south) and product.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < P; j++) begin
                if (j == 0) begin
                    a_eff_s[i][j] = feed_a_s[i];
                end else begin
                    a_eff_s[i][j] = a_pipe_q[i][j-1];
                end
                if (i == 0) begin
                    b_eff_s[i][j] = feed_b_s[j];
                end else begin
                    b_eff_s[i][j] = b_pipe_q[i-1][j];
                end
                prod_s[i][j] = mac_term(a_eff_s[i][j], b_eff_s[i][j], sm_q);
            end
        end
    end

    // Result truncation and saturation reduction.
    always_comb begin
        res_s     = {(M*P*OUT_WIDTH){1'b0}};
        sat_any_s = 1'b0;
        tr_s      = {(OUT_WIDTH+1){1'b0}};
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < P; j++) begin
                tr_s = out_trunc(acc_q[i][j], sm_q, satm_q);
                res_s[(i*P+j)*OUT_WIDTH +: OUT_WIDTH] = tr_s[OUT_WIDTH-1:0];
                sat_any_s = sat_any_s | tr_s[OUT_WIDTH];
            end
        end
    end

    // Control, operand latches, systolic pipes, accumulators and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            sm_q     <= 1'b0;
            satm_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            result_q <= {(M*P*OUT_WIDTH){1'b0}};
            for (int i = 0; i < M; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_lat_q[i][k] <= {DATA_WIDTH{1'b0}};
                end
            end
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < P; j++) begin
                    b_lat_q[k][j] <= {DATA_WIDTH{1'b0}};
                end
            end
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < P; j++) begin
                    a_pipe_q[i][j] <= {DATA_WIDTH{1'b0}};
                    b_pipe_q[i][j] <= {DATA_WIDTH{1'b0}};
                    acc_q[i][j]    <= {ACC_WIDTH{1'b0}};
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_OUT);
            if (state_q == S_OUT) begin
                result_q <= res_s;
                sat_q    <= sat_any_s;
            end else begin
                result_q <= result_q;
                sat_q    <= sat_q;
            end
            if (accept_s) begin
                sm_q   <= signed_mode;
                satm_q <= sat_mode;
                for (int i = 0; i < M; i++) begin
                    for (int k = 0; k < N; k++) begin
                        a_lat_q[i][k] <= matrix_a[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                for (int k = 0; k < N; k++) begin
                    for (int j = 0; j < P; j++) begin
                        b_lat_q[k][j] <= matrix_b[(k*P+j)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                // Pipes restart empty so no operand leaks in from the previous job.
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < P; j++) begin
                        a_pipe_q[i][j] <= {DATA_WIDTH{1'b0}};
                        b_pipe_q[i][j] <= {DATA_WIDTH{1'b0}};
                        if (!acc_mode) begin
                            acc_q[i][j] <= {ACC_WIDTH{1'b0}};
                        end else begin
                            acc_q[i][j] <= acc_q[i][j];
                        end
                    end
                end
            end else if (state_q == S_RUN) begin
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < P; j++) begin
                        a_pipe_q[i][j] <= a_eff_s[i][j];
                        b_pipe_q[i][j] <= b_eff_s[i][j];
                        acc_q[i][j]    <= acc_q[i][j] + prod_s[i][j];
                    end
                end
            end else begin
                sm_q <= sm_q;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result_c = result_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_systolic_mm_acc.sv
// Directed and randomised checks of systolic_mm_acc (4x4x4, 8-bit operands, 16-bit results).
module tb_systolic_mm_acc;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic         acc_mode;
    logic         sat_mode;
    logic [127:0] matrix_a;
    logic [127:0] matrix_b;
    logic         busy;
    logic         done;
    logic [255:0] result_c;
    logic         sat_flag;

    systolic_mm_acc dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .acc_mode   (acc_mode),
        .sat_mode   (sat_mode),
        .matrix_a   (matrix_a),
        .matrix_b   (matrix_b),
        .busy       (busy),
        .done       (done),
        .result_c   (result_c),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  ta [4][4];
    logic [7:0]  tb [4][4];
    logic [15:0] hc [4][4];
    logic [15:0] mc [4][4];
    logic        msat;
    logic [23:0] macc [4][4];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_m(input logic [7:0] m [4][4]);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                r[(i*4+k)*8 +: 8] = m[i][k];
        return r;
    endfunction

    function automatic logic [255:0] pack_hc();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[(i*4+j)*16 +: 16] = hc[i][j];
        return r;
    endfunction

    task automatic fill_ab(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k] = av;
                tb[i][k] = bv;
            end
    endtask

    task automatic fill_hc(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                hc[i][j] = v;
    endtask

    // Reference model: 24-bit accumulators persisting across jobs.
    task automatic model_job(input logic sgn, input logic acc, input logic sat);
        int pa, pb, s;
        msat = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (!acc) macc[i][j] = 24'd0;
                for (int k = 0; k < 4; k++) begin
                    pa = sgn ? int'($signed(ta[i][k])) : int'(ta[i][k]);
                    pb = sgn ? int'($signed(tb[k][j])) : int'(tb[k][j]);
                    macc[i][j] = macc[i][j] + 24'(pa * pb);
                end
                mc[i][j] = macc[i][j][15:0];
                if (sat && sgn) begin
                    s = int'($signed(macc[i][j]));
                    if (s > 32767) begin mc[i][j] = 16'h7FFF; msat = 1'b1; end
                    else if (s < -32768) begin mc[i][j] = 16'h8000; msat = 1'b1; end
                end else if (sat) begin
                    if (macc[i][j] > 24'd65535) begin mc[i][j] = 16'hFFFF; msat = 1'b1; end
                end
            end
    endtask

    task automatic start_job(input logic sgn, input logic acc, input logic sat);
        matrix_a    = pack_m(ta);
        matrix_b    = pack_m(tb);
        signed_mode = sgn;
        acc_mode    = acc;
        sat_mode    = sat;
        start       = 1'b1;
        model_job(sgn, acc, sat);
    endtask

    // Waits (bounded) for done; optionally injects a stray start pulse after posedge pulse_at.
    task automatic wait_done(input int pulse_at, output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (pulse_at > 1 && n == pulse_at) begin
                start = 1'b1; matrix_a = '1; matrix_b = '1;
            end else if (pulse_at > 1 && n == pulse_at + 1) begin
                start = 1'b0;
            end
            if (done) begin lat = n; break; end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic finish_job(input string tag, input logic esat, input int pulse_at);
        int   lat;
        logic bok;
        wait_done(pulse_at, lat, bok);
        chk({tag, " latency"}, 256'(lat), 256'd12);
        chk({tag, " busy"}, 256'(bok), 256'd1);
        chk({tag, " result"}, result_c, pack_hc());
        chk({tag, " sat"}, 256'(sat_flag), 256'(esat));
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_mode = 1'b0; sat_mode = 1'b0;
        matrix_a = '0; matrix_b = '0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) macc[i][j] = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 256'(busy), 256'd0);
        chk("reset done", 256'(done), 256'd0);
        chk("reset result", result_c, 256'd0);
        chk("reset sat", 256'(sat_flag), 256'd0);
        rst = 1'b0;

        // Signed identity: C = B sign-extended.
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k] = (i == k) ? 8'd1 : 8'd0;
                tb[i][k] = 8'(i*4 + k - 8);
                hc[i][k] = 16'(i*4 + k - 8);
            end
        @(negedge clk); start_job(1'b1, 1'b0, 1'b0);
        finish_job("identity", 1'b0, 0);

        // Unsigned max operands, wrapping then saturating.
        fill_ab(8'hFF, 8'hFF); fill_hc(16'hF804);
        @(negedge clk); start_job(1'b0, 1'b0, 1'b0);
        finish_job("umax wrap", 1'b0, 0);
        fill_hc(16'hFFFF);
        @(negedge clk); start_job(1'b0, 1'b0, 1'b1);
        finish_job("umax sat", 1'b1, 0);

        // Accumulate, second job issued in the first job's done cycle.
        fill_ab(8'd2, 8'd2); fill_hc(16'd16);
        @(negedge clk); start_job(1'b1, 1'b0, 1'b0);
        finish_job("acc job1", 1'b0, 0);
        fill_hc(16'd32);
        start_job(1'b1, 1'b1, 1'b0);
        finish_job("acc job2", 1'b0, 0);

        // Signed saturation both directions.
        fill_ab(8'h80, 8'h80); fill_hc(16'h7FFF);
        @(negedge clk); start_job(1'b1, 1'b0, 1'b1);
        finish_job("ssat pos", 1'b1, 0);
        fill_ab(8'h80, 8'h7F); fill_hc(16'h8000);
        @(negedge clk); start_job(1'b1, 1'b0, 1'b1);
        finish_job("ssat neg", 1'b1, 0);

        // Stray start during RUN is ignored.
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k] = (i == k) ? 8'd1 : 8'd0;
                tb[i][k] = 8'(i + k + 1);
                hc[i][k] = 16'(i + k + 1);
            end
        @(negedge clk); start_job(1'b0, 1'b0, 1'b0);
        finish_job("ignore", 1'b0, 4);
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("ignore single done", 256'(cnt), 256'd0);

        // Reset mid-RUN discards the job and clears the accumulators.
        fill_ab(8'd3, 8'd3);
        @(negedge clk); start_job(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 256'(busy), 256'd0);
        chk("abort result", result_c, 256'd0);
        chk("abort done", 256'(done), 256'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) macc[i][j] = 24'd0;
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("abort no done", 256'(cnt), 256'd0);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k] = (i == k) ? 8'd1 : 8'd0;
                tb[i][k] = (i == k) ? 8'd1 : 8'd0;
                hc[i][k] = (i == k) ? 16'd1 : 16'd0;
            end
        @(negedge clk); start_job(1'b1, 1'b1, 1'b0);
        finish_job("post-abort acc", 1'b0, 0);

        // Random regression against the reference model.
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) begin
                    ta[i][k] = 8'($urandom);
                    tb[i][k] = 8'($urandom);
                end
            @(negedge clk);
            start_job(1'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) hc[i][j] = mc[i][j];
            finish_job("random", msat, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_mm_acc.md
Name: systolic_mm_acc

Overview:
- Parametrised second-generation output-stationary systolic matrix multiplier: C = A x B (M x N times N x P).
- Adds separate accumulator and output widths, signed/unsigned operands, and accumulate-across-jobs mode (C += A x B).
- Adds saturating or wrapping output truncation with a sticky saturation flag, plus a busy/done handshake with back-to-back job issue.
- Sits behind the matrix-load logic; packed operand and result buses share the existing packing order.

Parameters:
- DATA_WIDTH, 8, operand element width.
- M, 4, rows of A and C.
- N, 4, columns of A = rows of B (reduction depth).
- P, 4, columns of B and C.
- ACC_WIDTH, 2*DATA_WIDTH+8, per-PE accumulator width.
- OUT_WIDTH, 2*DATA_WIDTH, result element width (OUT_WIDTH <= ACC_WIDTH).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only when idle or in the done cycle.
- signed_mode  in  1  1 = two's-complement operands/results, 0 = unsigned; sampled with start.
- acc_mode  in  1  0 = clear accumulators before the job, 1 = add onto existing accumulators; sampled with start.
- sat_mode  in  1  1 = saturate to OUT_WIDTH, 0 = keep low OUT_WIDTH bits; sampled with start.
- matrix_a  in  M*N*DATA_WIDTH  A[i][k] at bits (i*N+k)*DATA_WIDTH +: DATA_WIDTH; sampled with start.
- matrix_b  in  N*P*DATA_WIDTH  B[k][j] at bits (k*P+j)*DATA_WIDTH +: DATA_WIDTH; sampled with start.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse; result_c and sat_flag are valid from that cycle.
- result_c  out  M*P*OUT_WIDTH  C[i][j] at bits (i*P+j)*OUT_WIDTH +: OUT_WIDTH; held until the next done.
- sat_flag  out  1  high if any element of the last result saturated; updated with done.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result_c=0, sat_flag=0; all accumulators, operand latches, skew registers and counter cleared.
- Reset wins over everything, including mid-job; the in-flight job is discarded with no done.
- FSM states:
  - IDLE: start=1 -> latch matrix_a, matrix_b and the three mode bits; if acc_mode=0, clear accumulators; counter=0; go to RUN. start=0 -> stay.
  - RUN: for cnt = 0..M+N+P-3, each PE(i,j) does acc += a*b on the skewed operands. A[i][k] reaches PE(i,j) at cnt = i+j+k; B[k][j] arrives on the same cnt. Zeros are injected outside the valid window.
  - RUN exit: at cnt = M+N+P-3 go to OUT.
  - OUT: register result_c and sat_flag; done=1 for this cycle only; busy=1.
  - OUT exit: start=1 is accepted exactly as in IDLE, with no idle bubble; else go to IDLE.
- start while in RUN is ignored: not queued, inputs not latched.
- Latency: start sampled at edge E -> done high in the cycle after edge E+M+N+P-1, i.e. done is observed M+N+P cycles after the start cycle. Back-to-back job throughput is one job per M+N+P cycles.
- Arithmetic:
  - Products are full 2*DATA_WIDTH, sign- or zero-extended to ACC_WIDTH per signed_mode.
  - The accumulator wraps modulo 2^ACC_WIDTH; there is no overflow detection at the accumulator.
- Output truncation:
  - sat_mode=0: low OUT_WIDTH bits.
  - sat_mode=1, signed: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - sat_mode=1, unsigned: clamp to [0, 2^OUT_WIDTH-1].
  - sat_flag = OR of the per-element clamp events; sat_flag=0 when sat_mode=0.
- Accumulate mode:
  - Accumulators persist across jobs and are cleared only by rst or a job with acc_mode=0.
  - acc_mode=1 jobs with mixed signed_mode are legal: the raw bits are simply added.

Test Plan:
- Signed identity, M=N=P=4, DATA_WIDTH=8, acc_mode=0, sat_mode=0: A = I, B[k][j] = k*4+j-8 -> result_c == B sign-extended to 16 bits; done observed exactly 12 cycles after the start cycle; busy high throughout that window.
- Unsigned max operands: A = B = all 8'hFF, signed_mode=0 -> every C = 4*255*255 = 260100 wraps to 16'hF804 with sat_mode=0. With sat_mode=1 -> every C = 16'hFFFF and sat_flag=1.
- Accumulate, signed: job 1 with A = B = all 2, acc_mode=0 -> C = 16. Job 2, same operands, acc_mode=1, started in job 1's done cycle -> C = 32, with done pulses exactly 12 cycles apart.
- Signed saturation: A = B = all -128 -> true C = 65536, clamped to 32767, sat_flag=1. Then A = all -128, B = all 127 -> C = -65024, clamped to -32768.
- Ignore/abort: a second start pulse during RUN -> ignored, one done only, result from the first operands. Then rst raised mid-RUN -> next cycle busy=0, result_c=0, no done. A subsequent acc_mode=1 job with A = B = I -> C = I, because the accumulators were cleared.
- Random regression: 200 jobs with random operands and modes against a reference model on 16-bit results; zero mismatches.
